// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with two write ports (port 1 wins on
// an address collision), optional hardwired zero register, combinational or
// registered reads with optional same-cycle write bypass, and a per-register
// busy scoreboard for pending writebacks.
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   wr_en0/wr_addr0/wr_data0  write port 0
//   wr_en1/wr_addr1/wr_data1  write port 1 (priority port)
//   rd_addr_a/rd_data_a       read port A
//   rd_addr_b/rd_data_b       read port B
//   busy_set/busy_addr        mark a register as awaiting writeback
//   busy_a/busy_b             busy bit of rd_addr_a / rd_addr_b (combinational)
module regfile_mp #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 5,
   parameter int unsigned DEPTH        = 32,
   parameter int unsigned ZERO_REG     = 1,
   parameter int unsigned READ_LATENCY = 0,
   parameter int unsigned BYPASS       = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en0,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   output logic              busy_a,
   output logic              busy_b
);

   // Elaboration-time sanity check on the address space.
   if (DEPTH > (2 ** ADDR_W)) begin : gParamCheck
      $error("regfile_mp: DEPTH exceeds the address space");
   end

   // True for an address that maps to a real, writable register.
   function automatic logic isLive(input logic [ADDR_W-1:0] addr);
      return (32'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   logic [DATA_W-1:0] regArray [DEPTH];
   logic [DEPTH-1:0]  busyBits;

   // Writes that will actually land on this edge; nothing lands under reset.
   logic wrLive0, wrLive1;
   assign wrLive0 = reset_n && wr_en0 && isLive(wr_addr0);
   assign wrLive1 = reset_n && wr_en1 && isLive(wr_addr1);

   // Storage and scoreboard, one slice per register.
   for (genvar r = 0; r < DEPTH; r++) begin : gReg
      if ((ZERO_REG != 0) && (r == 0)) begin : gZero
         assign regArray[r] = '0;
         assign busyBits[r] = 1'b0;
      end else begin : gLive
         logic [DATA_W-1:0] value;
         logic              busy;
         logic              hit0, hit1, setHit;

         assign hit0   = wr_en0 && (wr_addr0 == ADDR_W'(r));
         assign hit1   = wr_en1 && (wr_addr1 == ADDR_W'(r));
         assign setHit = busy_set && (busy_addr == ADDR_W'(r));

         // Port 1 takes priority when both ports target this register.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               value <= '0;
            end else if (hit1) begin
               value <= wr_data1;
            end else if (hit0) begin
               value <= wr_data0;
            end
         end

         // A new producer (set) outranks the writeback of the old one (clear).
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               busy <= 1'b0;
            end else if (setHit) begin
               busy <= 1'b1;
            end else if (hit0 || hit1) begin
               busy <= 1'b0;
            end
         end

         assign regArray[r] = value;
         assign busyBits[r] = busy;
      end
   end

   // Array read muxes; unmatched (out-of-range) addresses fall through to 0.
   logic [DATA_W-1:0] arrA, arrB;
   logic              busyRdA, busyRdB;

   always_comb begin
      arrA    = '0;
      arrB    = '0;
      busyRdA = 1'b0;
      busyRdB = 1'b0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
         if (rd_addr_a == ADDR_W'(r)) begin
            arrA    = regArray[r];
            busyRdA = busyBits[r];
         end
         if (rd_addr_b == ADDR_W'(r)) begin
            arrB    = regArray[r];
            busyRdB = busyBits[r];
         end
      end
   end

   assign busy_a = busyRdA;
   assign busy_b = busyRdB;

   // Post-write view of each read address: same-cycle write data wins over
   // the array, port 1 over port 0.
   logic [DATA_W-1:0] fwdA, fwdB;

   always_comb begin
      fwdA = arrA;
      fwdB = arrB;
      if (wrLive1 && (wr_addr1 == rd_addr_a)) begin
         fwdA = wr_data1;
      end else if (wrLive0 && (wr_addr0 == rd_addr_a)) begin
         fwdA = wr_data0;
      end
      if (wrLive1 && (wr_addr1 == rd_addr_b)) begin
         fwdB = wr_data1;
      end else if (wrLive0 && (wr_addr0 == rd_addr_b)) begin
         fwdB = wr_data0;
      end
   end

   if (READ_LATENCY == 0) begin : gCombRead
      if (BYPASS != 0) begin : gBypass
         assign rd_data_a = fwdA;
         assign rd_data_b = fwdB;
      end else begin : gNoBypass
         assign rd_data_a = arrA;
         assign rd_data_b = arrB;
      end
   end else begin : gRegRead
      // Capturing the forwarded value gives write-first behaviour.
      logic [DATA_W-1:0] rdRegA, rdRegB;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            rdRegA <= '0;
            rdRegB <= '0;
         end else begin
            rdRegA <= fwdA;
            rdRegB <= fwdB;
         end
      end

      assign rd_data_a = rdRegA;
      assign rd_data_b = rdRegB;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed bench for regfile_mp. Three instances
// share the stimulus: u0 defaults (zero reg, comb read, bypass), u1 (no zero
// reg, registered read), u2 (zero reg, comb read, no bypass, DEPTH=24).
// Expected outputs are pushed to per-instance queues at drive time; monitors
// pop and compare on the falling edge.
module tb_regfile_mp;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_en0 = 1'b0, wr_en1 = 1'b0, busy_set = 1'b0;
   logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0, rd_addr_a = '0, rd_addr_b = '0, busy_addr = '0;
   logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;

   logic [DW-1:0] rdA [3];
   logic [DW-1:0] rdB [3];
   logic          bzA [3];
   logic          bzB [3];

   always #5 clock = ~clock;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .ZERO_REG(1), .READ_LATENCY(0), .BYPASS(1)) u0 (
      .clock(clock), .reset_n(reset_n),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdA[0]), .rd_data_b(rdB[0]),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy_a(bzA[0]), .busy_b(bzB[0]));

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .ZERO_REG(0), .READ_LATENCY(1), .BYPASS(1)) u1 (
      .clock(clock), .reset_n(reset_n),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdA[1]), .rd_data_b(rdB[1]),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy_a(bzA[1]), .busy_b(bzB[1]));

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(24), .ZERO_REG(1), .READ_LATENCY(0), .BYPASS(0)) u2 (
      .clock(clock), .reset_n(reset_n),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdA[2]), .rd_data_b(rdB[2]),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy_a(bzA[2]), .busy_b(bzB[2]));

   // Instance configurations as seen by the reference model.
   int cDepth [3] = '{32, 32, 24};
   bit cZero  [3] = '{1'b1, 1'b0, 1'b1};
   bit cLat   [3] = '{1'b0, 1'b1, 1'b0};
   bit cByp   [3] = '{1'b1, 1'b1, 1'b0};

   // Reference model: architectural register contents, busy flags and the
   // last value latched by a registered read port.
   logic [DW-1:0] mMem  [3][64];
   bit            mBusy [3][64];
   logic [DW-1:0] mRegA [3];
   logic [DW-1:0] mRegB [3];

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          ba;
      logic          bb;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];
   int   checks = 0;
   int   errors = 0;

   function automatic bit live(int i, int a);
      return (a < cDepth[i]) && !(cZero[i] && a == 0);
   endfunction

   task automatic modelClear();
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < 64; r++) begin
            mMem[i][r]  = '0;
            mBusy[i][r] = 1'b0;
         end
         mRegA[i] = '0;
         mRegB[i] = '0;
      end
   endtask

   // Combinational-read expectation for the inputs currently driven.
   function automatic logic [DW-1:0] combRead(int i, int a);
      if (!live(i, a)) return '0;
      if (cByp[i] && reset_n) begin
         if (wr_en1 && int'(wr_addr1) == a) return wr_data1;
         if (wr_en0 && int'(wr_addr0) == a) return wr_data0;
      end
      return mMem[i][a];
   endfunction

   task automatic pushExpected();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.a  = cLat[i] ? mRegA[i] : combRead(i, int'(rd_addr_a));
         e.b  = cLat[i] ? mRegB[i] : combRead(i, int'(rd_addr_b));
         e.ba = live(i, int'(rd_addr_a)) ? mBusy[i][int'(rd_addr_a)] : 1'b0;
         e.bb = live(i, int'(rd_addr_b)) ? mBusy[i][int'(rd_addr_b)] : 1'b0;
         case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   // Architectural effect of one clock edge.
   task automatic modelEdge();
      if (!reset_n) return;
      for (int i = 0; i < 3; i++) begin
         if (wr_en0 && live(i, int'(wr_addr0))) begin
            mMem[i][int'(wr_addr0)]  = wr_data0;
            mBusy[i][int'(wr_addr0)] = 1'b0;
         end
         if (wr_en1 && live(i, int'(wr_addr1))) begin
            mMem[i][int'(wr_addr1)]  = wr_data1;
            mBusy[i][int'(wr_addr1)] = 1'b0;
         end
         if (busy_set && live(i, int'(busy_addr)))
            mBusy[i][int'(busy_addr)] = 1'b1;
         mRegA[i] = live(i, int'(rd_addr_a)) ? mMem[i][int'(rd_addr_a)] : '0;
         mRegB[i] = live(i, int'(rd_addr_b)) ? mMem[i][int'(rd_addr_b)] : '0;
      end
   endtask

   // One clock of stimulus, entered and left at posedge+1.
   task automatic cyc(input bit e0, input int a0, input logic [DW-1:0] d0,
                      input bit e1, input int a1, input logic [DW-1:0] d1,
                      input int ra, input int rb, input bit bs, input int bsa,
                      input bit doReset);
      reset_n   = 1'b1;
      wr_en0    = e0;  wr_addr0 = AW'(a0); wr_data0 = d0;
      wr_en1    = e1;  wr_addr1 = AW'(a1); wr_data1 = d1;
      rd_addr_a = AW'(ra); rd_addr_b = AW'(rb);
      busy_set  = bs;  busy_addr = AW'(bsa);
      if (doReset) begin
         #2;
         reset_n = 1'b0;
         modelClear();
      end
      pushExpected();
      @(posedge clock);
      modelEdge();
      #1;
   endtask

   task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   task automatic checkOne(input string inst, input int i, input exp_t e);
      cmp({inst, ".rd_data_a"}, rdA[i], e.a);
      cmp({inst, ".rd_data_b"}, rdB[i], e.b);
      cmp({inst, ".busy_a"}, DW'(bzA[i]), DW'(e.ba));
      cmp({inst, ".busy_b"}, DW'(bzB[i]), DW'(e.bb));
   endtask

   // Monitor: compare whatever expectation was queued for this cycle.
   always @(negedge clock) begin
      if (q0.size() > 0) checkOne("u0", 0, q0.pop_front());
      if (q1.size() > 0) checkOne("u1", 1, q1.pop_front());
      if (q2.size() > 0) checkOne("u2", 2, q2.pop_front());
   end

   initial begin
      int a0, a1, ra, rb;
      modelClear();
      repeat (2) @(posedge clock);
      #1;
      // Reset state, then write r5 and lose a second write to reset mid-cycle.
      cyc(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 1, 5, 0);
      cyc(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0);
      cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0);
      // Write priority on a collision, then two distinct addresses.
      cyc(1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 8, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 7, 8, 0, 0, 0);
      cyc(1, 7, 32'h11111111, 1, 8, 32'h22222222, 7, 8, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 7, 8, 0, 0, 0);
      // Zero register write and busy_set.
      cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Bypass / no-bypass on r3.
      cyc(1, 3, 32'hCAFE0001, 0, 0, 0, 3, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0);
      // Registered read of r9 with a same-edge write, then address changes.
      cyc(1, 9, 32'h12345678, 0, 0, 0, 3, 9, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 9, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 7, 9, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 7, 9, 0, 0, 0);
      // Scoreboard: set, set+clear, clear, out-of-range set.
      cyc(0, 0, 0, 0, 0, 0, 4, 4, 1, 4, 0);
      cyc(1, 4, 32'h44440000, 0, 0, 0, 4, 4, 1, 4, 0);
      cyc(0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 0);
      cyc(0, 0, 0, 1, 4, 32'h44441111, 4, 4, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 4, 40, 1, 40, 0);
      cyc(0, 0, 0, 0, 0, 0, 40, 8, 1, 20, 0);
      cyc(1, 20, 32'h20202020, 0, 0, 0, 20, 40, 1, 26, 0);
      cyc(0, 0, 0, 0, 0, 0, 20, 26, 0, 0, 0);
      // Randomized traffic, addresses biased towards collisions.
      for (int n = 0; n < 400; n++) begin
         a0 = $urandom_range(0, 40);
         a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 40);
         ra = ($urandom_range(0, 2) == 0) ? a1 : $urandom_range(0, 40);
         rb = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 40);
         cyc(1'($urandom_range(0, 1)), a0, $urandom,
             1'($urandom_range(0, 1)), a1, $urandom,
             ra, rb, 1'($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0) ? ra : $urandom_range(0, 40),
             (n % 97) == 60);
      end
      @(negedge clock);
      #1;
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q0.size() + q1.size() + q2.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file that succeeds the single-write, dual-read 32x32 register bank in the CPU datapath. It adds the following:
- Two write ports with defined priority.
- Optional hardwired zero register.
- Selectable combinational or registered reads, with same-cycle write bypass.
- Per-register busy scoreboard used by the issue stage to detect pending writebacks.

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, address width
DEPTH, 32, number of implemented registers (must be <= 2**ADDR_W)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
READ_LATENCY, 0, 0 = combinational read, 1 = registered read
BYPASS, 1, READ_LATENCY=0 only: 1 = same-cycle write data forwarded to read outputs

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
wr_en0  in  1  write port 0 enable
wr_addr0  in  ADDR_W  write port 0 address
wr_data0  in  DATA_W  write port 0 data
wr_en1  in  1  write port 1 enable (priority port)
wr_addr1  in  ADDR_W  write port 1 address
wr_data1  in  DATA_W  write port 1 data
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
busy_set  in  1  mark busy_addr as pending writeback
busy_addr  in  ADDR_W  scoreboard set address
busy_a  out  1  busy bit of rd_addr_a
busy_b  out  1  busy bit of rd_addr_b

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All DEPTH registers cleared to 0.
  - All busy bits cleared to 0.
  - Registered rd_data_a/b cleared to 0 when READ_LATENCY=1.
  - Writes, busy_set and read-register updates are blocked while reset_n=0.
  - Reset asserted mid-write: the write is lost and the register reads 0.
- Writes (posedge clock):
  - Port k writes wr_data_k to wr_addr_k when wr_en_k=1 and wr_addr_k<DEPTH.
  - With ZERO_REG=1, writes to address 0 are discarded.
  - Both ports enabled to the same address: port 1 data stored, port 0 data dropped.
  - Different addresses: both stored in the same edge.
- Scoreboard (posedge clock):
  - Busy bit for an address is cleared by any accepted write to it on either port.
  - busy_set=1 sets busy[busy_addr].
  - Set and clear of the same address on one edge: set wins; the bit stays 1 because a new producer has been issued.
  - busy_addr>=DEPTH is ignored. With ZERO_REG=1, address 0 is ignored.
  - busy_a/busy_b are combinational from the current busy bits and rd_addr_a/b. They read 0 for address >=DEPTH or zero register.
  - busy_a/b are not bypassed: a clear takes effect the cycle after the write edge.
- Reads, READ_LATENCY=0:
  - rd_data is combinational from the array.
  - BYPASS=1: if the read address matches an accepted write in the same cycle, the write data is forwarded (port 1 over port 0).
  - BYPASS=0: pre-write array contents are returned; the new value appears after the edge.
- Reads, READ_LATENCY=1:
  - rd_data is registered at posedge and valid one cycle after the address is presented.
  - The captured value is the post-write content, so a same-edge write is visible (write-first). BYPASS is ignored.
- Read boundary rules:
  - Address >=DEPTH reads 0.
  - With ZERO_REG=1, address 0 always reads 0.
- No undefined outputs after reset.
- No internal state other than the array, the busy bits and the optional read registers.

Test Plan:
1. Reset then read: assert reset_n=0 mid-run after writing 0xDEADBEEF to r5; read r5 -> 0 and busy_a=0, with rd_data 0 in both latency modes.
2. Write priority: wr_en0=wr_en1=1, both addr 7, data0=0x11111111, data1=0x22222222; next cycle read r7 -> 0x22222222. Repeat with addrs 7/8 -> r7=0x11111111, r8=0x22222222.
3. Zero register: write 0xFFFFFFFF to r0 and busy_set on r0 -> rd_data=0, busy=0. Repeat with ZERO_REG=0 -> rd_data=0xFFFFFFFF, busy=1 until written.
4. Bypass (LATENCY=0, BYPASS=1): write 0xCAFE0001 to r3 while rd_addr_a=3 -> rd_data_a=0xCAFE0001 in the same cycle. BYPASS=0 -> old value that cycle, new value next cycle.
5. Registered read (LATENCY=1): present rd_addr_b=9 while writing 0x12345678 to r9 on port 0 -> rd_data_b=0x12345678 one cycle later; an address change is reflected after exactly one edge.
6. Scoreboard: busy_set r4 -> busy_a=1 next cycle. Write r4 with a simultaneous busy_set r4 -> busy stays 1. Write r4 alone -> busy_a=0 next cycle. busy_addr=40 with DEPTH=32 -> no bit set.
